dac_sequencer: RTL and testbench
================================

Name: dac_sequencer

Overview:
- Sample-playback controller that sequences the 16-bit `o_digital` bus feeding the analog macro.
- The host loads up to DEPTH 16-bit codes byte-wise through a small command port driven from the `ui_in`/`uio_in` pins by `digital_top`.
- It then plays them out at a programmable rate, either one-shot or looped, with start/stop control and status flags.

Parameters:
- DEPTH, 8, number of sample slots; power of two, 2..16.
- DIV_W, 8, width of the sample-period divider register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted this cycle when high together with cmd_valid.
- cmd_op  input  2  opcode: 00 WR_LO, 01 WR_HI, 10 SET_DIV, 11 CTRL.
- cmd_data  input  8  command payload.
- o_digital  output  16  code driven to the analog block; registered.
- sample_strobe  output  1  one-cycle pulse in each cycle a new code appears on o_digital.
- busy  output  1  high in PLAY.
- done  output  1  one-cycle pulse when a one-shot sequence completes.
- count  output  $clog2(DEPTH)+1  number of loaded samples.
- overflow  output  1  sticky; a WR_HI was issued with count==DEPTH.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst_n` is synchronous and active-low, sampled on rising `clk`.
- Reset values:
  - o_digital=0, sample_strobe=0, busy=0, done=0, count=0, overflow=0.
  - div=0, loop=0, lo_stage=0, state=IDLE.
  - Sample memory is not reset.
- Reset asserted mid-PLAY forces all of the above on the next edge; no done pulse.
- Handshake:
  - A command fires on the rising edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE) || (cmd_op==CTRL); it is combinational from state and cmd_op.
- WR_LO: lo_stage <= cmd_data.
- WR_HI:
  - If count<DEPTH: mem[count] <= {cmd_data, lo_stage} and count <= count+1.
  - Else the write is dropped and overflow <= 1.
- SET_DIV: div <= cmd_data[DIV_W-1:0], zero-extended if DIV_W>8. The sample period is div+1 cycles.
- CTRL: bits [0] start, [1] stop, [2] loop, [3] clear. The loop flag is updated from bit2 on every accepted CTRL.
  - In IDLE:
    - clear → count<=0, overflow<=0.
    - start with count>0 (after applying clear in the same command) → PLAY.
    - start with count==0 → ignored: no state change, no strobe, no done.
  - In PLAY:
    - stop → IDLE next edge; o_digital holds its value; no done pulse.
    - start without stop → restart at index 0.
    - stop and start together → stop wins.
    - clear is ignored.
- State machine (IDLE, PLAY):
  - IDLE→PLAY on an accepted start at edge T.
    - At edge T: idx<=0, o_digital<=mem[0], sample_strobe=1 for cycle T+1, divider counter<=div.
  - In PLAY the divider counter decrements each edge. When it is 0 at an edge:
    - If idx<count-1: idx<=idx+1, o_digital<=mem[idx+1], strobe, counter<=div.
    - Else if loop=1: idx<=0, o_digital<=mem[0], strobe, counter<=div.
    - Else: state<=IDLE, done=1 for one cycle, no strobe, o_digital holds the last sample.
  - Each sample is held exactly div+1 cycles. With div=0 the code changes every cycle.
- busy is registered and equals (state==PLAY).
- count is stable during PLAY because only CTRL is accepted there.
- Arithmetic: idx and count are unsigned. idx wraps only through the explicit loop rule, never by overflow.

Optional Feature:
- Macro: `DAC_SEQ_MIDSCALE_EN`.
- Defined:
  - Reset value of o_digital is 16'h8000.
  - On every PLAY→IDLE transition (one-shot completion or stop), o_digital <= 16'h8000 at that same edge.
  - done and strobe behaviour is otherwise unchanged; no strobe for the midscale return.
- Undefined: reset value is 0 and o_digital holds its last value in IDLE.

Test Plan:
- Load and one-shot:
  - Stimulus: WR_LO 34, WR_HI 12, WR_LO 78, WR_HI 56, SET_DIV 2, CTRL 01.
  - Response: o_digital=1234 for 3 cycles then 5678 for 3 cycles.
  - Strobes 3 cycles apart; done pulses on the edge after the sixth cycle; busy falls with it; o_digital stays 5678 (16'h8000 with `DAC_SEQ_MIDSCALE_EN`).
- Loop and stop:
  - Stimulus: same two samples, div=0, CTRL 05.
  - Response: o_digital alternates 1234/5678 every cycle with strobe each cycle.
  - Then CTRL 02 → busy=0 next edge, no done, value held.
- Overflow:
  - Stimulus: with DEPTH=8, 9 WR_HI commands.
  - Response: count=8, overflow=1, mem[7] unchanged by the 9th write.
  - Then CTRL 08 → count=0, overflow=0.
- Backpressure:
  - Stimulus: during PLAY, present WR_HI and SET_DIV.
  - Response: cmd_ready=0, count and div unchanged.
  - Then CTRL 03 → stop wins: IDLE next edge.
- Empty start and restart:
  - CTRL 01 with count=0 → busy stays 0, no strobe.
  - Load 3 samples, start, then mid-second-sample issue CTRL 01 → o_digital=mem[0] with strobe on the next edge.
- Reset mid-operation:
  - Stimulus: rst_n low for 1 cycle during looped PLAY.
  - Response: next edge all outputs at reset values (o_digital=0, or 16'h8000 with `DAC_SEQ_MIDSCALE_EN`); count=0, no done.

Source files
------------

// File: rtl/dac_sequencer.sv
// rtl/dac_sequencer.sv - sample-playback sequencer driving the 16-bit analog code bus
//
// Purpose: stores up to DEPTH 16-bit codes loaded byte-wise through a command
// port and plays them onto o_digital at a programmable period (div+1 cycles),
// one-shot or looped.
//
// Optional build macro: DAC_SEQ_MIDSCALE_EN
//   When defined, o_digital resets to 16'h8000 and returns to 16'h8000 on every
//   PLAY->IDLE transition (stop or one-shot completion).
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      command accepted when high together with cmd_valid
//   cmd_op         00 WR_LO, 01 WR_HI, 10 SET_DIV, 11 CTRL
//   cmd_data       command payload (CTRL: [0] start [1] stop [2] loop [3] clear)
//   o_digital      registered code to the analog block
//   sample_strobe  one-cycle pulse when a new code appears on o_digital
//   busy           high while playing
//   done           one-cycle pulse when a one-shot sequence completes
//   count          number of loaded samples
//   overflow       sticky, WR_HI issued while memory was full

module dac_sequencer #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_data,
  output logic [15:0]              o_digital,
  output logic                     sample_strobe,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] OP_WR_LO   = 2'b00;
  localparam logic [1:0] OP_WR_HI   = 2'b01;
  localparam logic [1:0] OP_SET_DIV = 2'b10;
  localparam logic [1:0] OP_CTRL    = 2'b11;

`ifdef DAC_SEQ_MIDSCALE_EN
  localparam logic [15:0] IDLE_CODE  = 16'h8000;
  localparam logic        MID_RETURN = 1'b1;
`else
  localparam logic [15:0] IDLE_CODE  = 16'h0000;
  localparam logic        MID_RETURN = 1'b0;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        out_q, out_d;
  logic               strobe_q, strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   tick_q, tick_d;
  logic               loop_q, loop_d;
  logic [7:0]         lo_q, lo_d;

  logic [15:0]        mem_q [DEPTH];
  logic               mem_we;

  logic               cmd_fire;
  logic               ctrl_fire;
  logic [IDX_W-1:0]   idx_next;
  logic               last_sample;

  // Only CTRL is accepted while playing, which keeps count and div frozen.
  assign cmd_ready = (state_q == S_IDLE) || (cmd_op == OP_CTRL);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ctrl_fire = cmd_fire && (cmd_op == OP_CTRL);

  // idx_next only feeds the memory when idx+1 < count, so its wrap is harmless.
  assign idx_next    = idx_q + 1'b1;
  assign last_sample = !(({1'b0, idx_q} + ONE_C) < count_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    tick_d   = tick_q;
    loop_d   = loop_q;
    lo_d     = lo_q;
    mem_we   = 1'b0;

    if (cmd_fire) begin
      case (cmd_op)
        OP_WR_LO: lo_d = cmd_data;
        OP_WR_HI: begin
          if (count_q < DEPTH_C) begin
            mem_we  = 1'b1;
            count_d = count_q + ONE_C;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_SET_DIV: div_d = DIV_W'(cmd_data);
        default:    loop_d = cmd_data[2];
      endcase
    end

    if (state_q == S_IDLE) begin
      if (ctrl_fire) begin
        if (cmd_data[3]) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end
        // Start sees the count after a same-command clear.
        if (cmd_data[0] && (count_d != '0)) begin
          state_d  = S_PLAY;
          idx_d    = '0;
          out_d    = mem_q[0];
          strobe_d = 1'b1;
          tick_d   = div_q;
        end
      end
    end else begin
      if (ctrl_fire && cmd_data[1]) begin
        // Stop has priority over start; no done pulse on an abort.
        state_d = S_IDLE;
        if (MID_RETURN) out_d = IDLE_CODE;
      end else if (ctrl_fire && cmd_data[0]) begin
        idx_d    = '0;
        out_d    = mem_q[0];
        strobe_d = 1'b1;
        tick_d   = div_q;
      end else if (tick_q != '0) begin
        tick_d = tick_q - 1'b1;
      end else if (!last_sample) begin
        idx_d    = idx_next;
        out_d    = mem_q[idx_next];
        strobe_d = 1'b1;
        tick_d   = div_q;
      end else if (loop_q) begin
        idx_d    = '0;
        out_d    = mem_q[0];
        strobe_d = 1'b1;
        tick_d   = div_q;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (MID_RETURN) out_d = IDLE_CODE;
      end
    end

    busy_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      out_q    <= IDLE_CODE;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= '0;
      tick_q   <= '0;
      loop_q   <= 1'b0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      loop_q   <= loop_d;
      lo_q     <= lo_d;
    end
  end

  // Sample memory carries no reset; writes are simply blocked during reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[count_q[IDX_W-1:0]] <= {cmd_data, lo_q};
    end
  end

  assign o_digital     = out_q;
  assign sample_strobe = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign count         = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_dac_sequencer.sv
// tb/tb_dac_sequencer.sv - self-checking bench for dac_sequencer

module tb_dac_sequencer;

`ifdef DAC_SEQ_MIDSCALE_EN
  localparam logic [15:0] IDLE_CODE = 16'h8000;
  localparam bit          MIDSCALE  = 1'b1;
`else
  localparam logic [15:0] IDLE_CODE = 16'h0000;
  localparam bit          MIDSCALE  = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [15:0] o_digital;
  logic        sample_strobe;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic        overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q [$];
  logic [15:0] mdl_mem [8];
  int          mdl_count = 0;

  dac_sequencer #(.DEPTH(8), .DIV_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .o_digital     (o_digital),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .done          (done),
    .count         (count),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: drive at a negedge, command fires on the next posedge,
  // return at the following negedge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic load_sample(input logic [15:0] v);
    send_cmd(2'b00, v[7:0]);
    send_cmd(2'b01, v[15:8]);
    if (mdl_count < 8) begin
      mdl_mem[mdl_count] = v;
      mdl_count++;
    end
  endtask

  task automatic clear_all();
    send_cmd(2'b11, 8'h08);
    mdl_count = 0;
  endtask

  task automatic push_play();
    for (int i = 0; i < mdl_count; i++) exp_q.push_back(mdl_mem[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_digital !== IDLE_CODE || sample_strobe !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: o=%h strobe=%b busy=%b done=%b count=%0d ovf=%b, want o=%h all others 0",
               o_digital, sample_strobe, busy, done, count, overflow, IDLE_CODE);
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_one_shot();
    int first_k = 0, second_k = 0, n_strobe = 0, done_k = 0, n_done = 0;
    logic [15:0] e;
    clear_all();
    load_sample(16'h1234);
    load_sample(16'h5678);
    send_cmd(2'b10, 8'd2);
    tests_run++;
    if (count !== 4'(mdl_count)) begin
      tests_failed++;
      $display("FAIL oneshot_count: got %0d want %0d", count, mdl_count);
    end
    push_play();
    send_cmd(2'b11, 8'h01);
    for (int k = 1; k <= 9; k++) begin
      if (sample_strobe) begin
        n_strobe++;
        if (n_strobe == 1) first_k = k;
        if (n_strobe == 2) second_k = k;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL oneshot_sb: unexpected strobe at cycle %0d o=%h", k, o_digital);
        end else begin
          e = exp_q.pop_front();
          if (o_digital !== e) begin
            tests_failed++;
            $display("FAIL oneshot_sb: got %h want %h", o_digital, e);
          end
        end
      end
      if (done) begin
        n_done++;
        if (done_k == 0) done_k = k;
      end
      if (k <= 6) begin
        tests_run++;
        if (o_digital !== ((k <= 3) ? 16'h1234 : 16'h5678) || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL oneshot_hold c%0d: o=%h busy=%b want o=%h busy=1", k, o_digital, busy,
                   (k <= 3) ? 16'h1234 : 16'h5678);
        end
      end
      if (k == 7) begin
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b1 || o_digital !== (MIDSCALE ? 16'h8000 : 16'h5678)) begin
          tests_failed++;
          $display("FAIL oneshot_end: busy=%b done=%b o=%h want busy=0 done=1 o=%h", busy, done,
                   o_digital, MIDSCALE ? 16'h8000 : 16'h5678);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (n_strobe !== 2 || first_k !== 1 || second_k !== 4) begin
      tests_failed++;
      $display("FAIL oneshot_strobes: n=%0d at %0d,%0d want 2 at 1,4", n_strobe, first_k, second_k);
    end
    tests_run++;
    if (n_done !== 1 || done_k !== 7) begin
      tests_failed++;
      $display("FAIL oneshot_done: n=%0d at %0d want 1 at 7", n_done, done_k);
    end
    exp_q.delete();
  endtask

  task automatic test_loop_stop();
    logic [15:0] e;
    logic [15:0] held;
    int n_done = 0;
    clear_all();
    load_sample(16'h1234);
    load_sample(16'h5678);
    send_cmd(2'b10, 8'd0);
    for (int r = 0; r < 3; r++) push_play();
    send_cmd(2'b11, 8'h05);
    for (int k = 1; k <= 6; k++) begin
      tests_run++;
      if (sample_strobe !== 1'b1 || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL loop_strobe c%0d: strobe=%b queue=%0d want strobe=1", k, sample_strobe, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (o_digital !== e) begin
          tests_failed++;
          $display("FAIL loop_sb c%0d: got %h want %h", k, o_digital, e);
        end
      end
      @(negedge clk);
    end
    send_cmd(2'b11, 8'h02);
    held = MIDSCALE ? 16'h8000 : 16'h1234;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_strobe !== 1'b0 || o_digital !== held) begin
      tests_failed++;
      $display("FAIL loop_stop: busy=%b done=%b strobe=%b o=%h want 0 0 0 %h",
               busy, done, sample_strobe, o_digital, held);
    end
    for (int k = 0; k < 3; k++) begin
      if (done) n_done++;
      tests_run++;
      if (o_digital !== held) begin
        tests_failed++;
        $display("FAIL loop_hold: got %h want %h", o_digital, held);
      end
      @(negedge clk);
    end
    tests_run++;
    if (n_done !== 0) begin
      tests_failed++;
      $display("FAIL loop_nodone: got %0d done pulses want 0", n_done);
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    int n_strobe = 0, n_done = 0;
    clear_all();
    for (int i = 0; i < 9; i++) load_sample(16'hA000 + 16'(i));
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_flags: count=%0d ovf=%b want 8 1", count, overflow);
    end
    send_cmd(2'b10, 8'd0);
    push_play();
    send_cmd(2'b11, 8'h01);
    for (int k = 1; k <= 12; k++) begin
      if (done) n_done++;
      if (sample_strobe) begin
        n_strobe++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL ovf_sb: unexpected strobe o=%h", o_digital);
        end else begin
          e = exp_q.pop_front();
          if (o_digital !== e) begin
            tests_failed++;
            $display("FAIL ovf_sb: got %h want %h", o_digital, e);
          end
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (n_strobe !== 8 || n_done !== 1 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL ovf_play: strobes=%0d done=%0d left=%0d want 8 1 0", n_strobe, n_done, exp_q.size());
    end
    clear_all();
    tests_run++;
    if (count !== 4'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: count=%0d ovf=%b want 0 0", count, overflow);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    int strobe_k = 0, n_done = 0;
    clear_all();
    load_sample(16'hBEEF);
    load_sample(16'h0F0F);
    send_cmd(2'b10, 8'd3);
    push_play();
    send_cmd(2'b11, 8'h01);
    if (sample_strobe && exp_q.size() != 0) e = exp_q.pop_front();
    cmd_op = 2'b01; cmd_data = 8'h55; cmd_valid = 1'b1;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready_wrhi: got %b want 0", cmd_ready);
    end
    @(negedge clk);
    cmd_op = 2'b10; cmd_data = 8'hFF;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready_div: got %b want 0", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      if (sample_strobe) begin
        if (strobe_k == 0) strobe_k = k;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL bp_sb: unexpected strobe o=%h", o_digital);
        end else begin
          e = exp_q.pop_front();
          if (o_digital !== e) begin
            tests_failed++;
            $display("FAIL bp_sb: got %h want %h", o_digital, e);
          end
        end
      end
      if (k < 6) @(negedge clk);
    end
    tests_run++;
    if (strobe_k !== 5) begin
      tests_failed++;
      $display("FAIL bp_div_kept: second strobe at cycle %0d want 5", strobe_k);
    end
    cmd_op = 2'b11; cmd_data = 8'h03; cmd_valid = 1'b1;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_ctrl: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_strobe !== 1'b0 || count !== 4'd2) begin
      tests_failed++;
      $display("FAIL bp_stop_wins: busy=%b done=%b strobe=%b count=%0d want 0 0 0 2",
               busy, done, sample_strobe, count);
    end
    for (int k = 0; k < 4; k++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    tests_run++;
    if (n_done !== 0) begin
      tests_failed++;
      $display("FAIL bp_after_stop: %0d cycles with done/busy want 0", n_done);
    end
    exp_q.delete();
  endtask

  task automatic test_empty_restart();
    logic [15:0] e;
    int bad = 0;
    clear_all();
    send_cmd(2'b11, 8'h01);
    for (int k = 0; k < 4; k++) begin
      if (busy || sample_strobe || done) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL empty_start: %0d active cycles want 0", bad);
    end
    load_sample(16'hC001);
    load_sample(16'hC002);
    load_sample(16'hC003);
    send_cmd(2'b10, 8'd2);
    exp_q.push_back(mdl_mem[0]);
    exp_q.push_back(mdl_mem[1]);
    send_cmd(2'b11, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      if (sample_strobe) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL restart_sb: unexpected strobe o=%h", o_digital);
        end else begin
          e = exp_q.pop_front();
          if (o_digital !== e) begin
            tests_failed++;
            $display("FAIL restart_sb: got %h want %h", o_digital, e);
          end
        end
      end
      @(negedge clk);
    end
    exp_q.push_back(mdl_mem[0]);
    exp_q.push_back(mdl_mem[1]);
    send_cmd(2'b11, 8'h01);
    tests_run++;
    if (sample_strobe !== 1'b1 || o_digital !== 16'hC001 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_first: strobe=%b o=%h busy=%b want 1 c001 1", sample_strobe, o_digital, busy);
    end
    for (int k = 6; k <= 9; k++) begin
      if (sample_strobe) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL restart_sb: unexpected strobe o=%h", o_digital);
        end else begin
          e = exp_q.pop_front();
          if (o_digital !== e) begin
            tests_failed++;
            $display("FAIL restart_sb: got %h want %h", o_digital, e);
          end
        end
      end
      @(negedge clk);
    end
    send_cmd(2'b11, 8'h02);
    tests_run++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_end: left=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_play();
    int bad = 0;
    clear_all();
    load_sample(16'h1234);
    load_sample(16'h5678);
    send_cmd(2'b10, 8'd0);
    send_cmd(2'b11, 8'h05);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (o_digital !== IDLE_CODE || sample_strobe !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_values: o=%h strobe=%b busy=%b done=%b count=%0d ovf=%b want o=%h rest 0",
               o_digital, sample_strobe, busy, done, count, overflow, IDLE_CODE);
    end
    rst_n = 1'b1;
    mdl_count = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy || sample_strobe || done) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL midreset_after: %0d active cycles want 0", bad);
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_loop_stop();
    test_overflow();
    test_backpressure();
    test_empty_restart();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
